twiddle_loader: RTL and testbench

- Write-side counterpart of the FFT twiddle read path. Accepts a stream of complex twiddle coefficients over a valid/ready handshake and writes them sequentially into the twiddle memory.
- Drives the memory's chip-select, write-enable, address and real/imag data.
- Sits between the host/config interface and the twiddle storage. Must complete before any FFT run that reads twiddles.

---
 rtl/twiddle_loader_pkg.sv | 15 +
 rtl/twiddle_loader_ctrl.sv | 66 ++++++
 rtl/twiddle_loader.sv | 80 ++++++++
 tb/tb_twiddle_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_loader_pkg.sv
// Shared FFT twiddle memory geometry and loader state encoding.
// The read path imports the same defaults so both sides agree on memory layout.
package twiddle_loader_pkg;

  localparam int TW_WORDSIZE = 16;
  localparam int TW_ADDRSIZE = 5;
  localparam int TW_NUMADDR  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/twiddle_loader_ctrl.sv
// Loader FSM and write-address counter; accepts beats only in LOAD.
// done/busy are registered; in_ready is decoded directly from state.
module twiddle_loader_ctrl
  import twiddle_loader_pkg::*;
#(
  parameter int ADDRSIZE = TW_ADDRSIZE,
  parameter int NUMADDR  = TW_NUMADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                accept,
  output logic [ADDRSIZE-1:0] count,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDRSIZE-1:0] LAST = ADDRSIZE'(NUMADDR - 1);

  state_t state;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          // Counter holds on the final beat so it never wraps when NUMADDR == 2**ADDRSIZE.
          if (accept) begin
            if (count == LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              count <= count + ADDRSIZE'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/twiddle_loader.sv
// Streams NUMADDR complex twiddles into the twiddle memory, one registered write per accepted beat.
// Optional running XOR checksum output under TWIDDLE_LOADER_CHKSUM_EN.
module twiddle_loader
  import twiddle_loader_pkg::*;
#(
  parameter int WORDSIZE = TW_WORDSIZE,
  parameter int ADDRSIZE = TW_ADDRSIZE,
  parameter int NUMADDR  = TW_NUMADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in_r,
  input  logic [WORDSIZE-1:0] in_i,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata_r,
  output logic [WORDSIZE-1:0] mem_wdata_i,
  output logic                busy,
  output logic                done
`ifdef TWIDDLE_LOADER_CHKSUM_EN
  ,
  output logic [2*WORDSIZE-1:0] chksum
`endif
);

  logic                accept;
  logic [ADDRSIZE-1:0] count;

  twiddle_loader_ctrl #(
    .ADDRSIZE(ADDRSIZE),
    .NUMADDR (NUMADDR)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .accept  (accept),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  // Address and data hold between writes; only the strobes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata_r <= '0;
      mem_wdata_i <= '0;
    end else begin
      mem_cs <= accept;
      mem_we <= accept;
      if (accept) begin
        mem_addr    <= count;
        mem_wdata_r <= in_r;
        mem_wdata_i <= in_i;
      end
    end
  end

`ifdef TWIDDLE_LOADER_CHKSUM_EN
  // busy is low exactly in IDLE, so start & ~busy marks the IDLE->LOAD transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (start && !busy) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= chksum ^ {in_r, in_i};
    end
  end
`endif

endmodule

// File: tb/tb_twiddle_loader.sv
// Directed bench for twiddle_loader with a beat-level reference model and per-cycle compare.
module tb_twiddle_loader;

  localparam int NA = 32;
  localparam int P_IDLE = 0, P_LOAD = 1, P_FIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_r = '0;
  logic [15:0] in_i = '0;
  logic        mem_cs, mem_we, busy, done;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata_r, mem_wdata_i;
`ifdef TWIDDLE_LOADER_CHKSUM_EN
  logic [31:0] chksum;
`endif

  int checks = 0;
  int failures = 0;

  twiddle_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_i       (in_i),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata_r(mem_wdata_r),
    .mem_wdata_i(mem_wdata_i),
    .busy       (busy),
    .done       (done)
`ifdef TWIDDLE_LOADER_CHKSUM_EN
    ,
    .chksum     (chksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase of the load, number of beats taken, last write seen on the port.
  int          m_phase = P_IDLE;
  int          m_n = 0;
  logic        m_cs = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [15:0] m_r = '0, m_i = '0;
  logic [31:0] m_chk = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_n = 0; m_cs = 1'b0;
      m_addr = '0; m_r = '0; m_i = '0; m_chk = '0;
    end else begin
      m_cs = 1'b0;
      if (m_phase == P_IDLE) begin
        if (start) begin m_phase = P_LOAD; m_n = 0; m_chk = '0; end
      end else if (m_phase == P_LOAD) begin
        if (in_valid) begin
          m_cs = 1'b1; m_addr = 5'(m_n); m_r = in_r; m_i = in_i;
          m_chk = m_chk ^ {in_r, in_i};
          m_n++;
          if (m_n == NA) m_phase = P_FIN;
        end
      end else begin
        m_phase = P_IDLE;
      end
    end
  end

  int wlog[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    chk("cmp_ready", in_ready, m_phase == P_LOAD);
    chk("cmp_busy",  busy,     m_phase != P_IDLE);
    chk("cmp_done",  done,     m_phase == P_FIN);
    chk("cmp_cs",    mem_cs,   m_cs);
    chk("cmp_we",    mem_we,   m_cs);
    chk("cmp_addr",  mem_addr, m_addr);
    chk("cmp_wr",    mem_wdata_r, m_r);
    chk("cmp_wi",    mem_wdata_i, m_i);
`ifdef TWIDDLE_LOADER_CHKSUM_EN
    if (m_phase != P_LOAD) chk("cmp_chksum", chksum, m_chk);
`endif
    if (mem_we) wlog.push_back(int'(mem_addr));
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dr(input int mode, input int k);
    logic [15:0] v;
    v = 16'(k);
    case (mode)
      0: return v;
      1: return v + 16'h0100;
      2: return 16'h0001;
      default: return (k == 0) ? 16'h00FF : 16'h0001;
    endcase
  endfunction

  function automatic logic [15:0] di(input int mode, input int k);
    logic [15:0] v;
    v = 16'(k);
    case (mode)
      0: return ~v;
      1: return v ^ 16'h5A5A;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_log(input string nm);
    bit ok;
    ok = 1'b1;
    foreach (wlog[j]) if (wlog[j] != j) ok = 1'b0;
    chk({nm, "_nwrites"}, wlog.size(), NA);
    chk({nm, "_contig"}, ok, 1);
    chk({nm, "_ndone"}, done_cnt, 1);
  endtask

  // One full load: gap idle cycles between beats, start re-pulsed alongside beat 'poke'.
  task automatic run_load(input string nm, input int gap, input int mode, input int poke);
    wlog.delete();
    done_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < NA; k++) begin
      in_valid = 1'b1; in_r = dr(mode, k); in_i = di(mode, k);
      start = (k == poke);
      tick();
      start = 1'b0;
      if (k == NA - 1) begin
        #2;
        chk({nm, "_done_pulse"}, done, 1);
        chk({nm, "_last_addr"}, mem_addr, 5'd31);
        chk({nm, "_last_r"}, mem_wdata_r, dr(mode, k));
        chk({nm, "_last_i"}, mem_wdata_i, di(mode, k));
`ifdef TWIDDLE_LOADER_CHKSUM_EN
        if (mode == 2) chk({nm, "_chksum"}, chksum, 32'h00000000);
        if (mode == 3) chk({nm, "_chksum"}, chksum, 32'h00FE0000);
`endif
      end
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    // An extra offered beat must not be taken.
    in_valid = 1'b1; in_r = 16'hDEAD; in_i = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    #2;
    chk({nm, "_ready_after"}, in_ready, 0);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_done_after"}, done, 0);
    tick();
    check_log(nm);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    #2;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_done", done, 0);

    run_load("full", 0, 0, -1);
    run_load("throttle", 2, 0, -1);

    // Partial load of 10 beats, then reset mid-load.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_r = dr(0, k); in_i = di(0, k);
      tick();
    end
    in_valid = 1'b0;
    #2;
    chk("part_addr9", mem_addr, 5'd9);
    chk("part_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("midrst_cs", mem_cs, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wr", mem_wdata_r, 0);
    tick();
    rst = 1'b0;
    tick();
    run_load("restart", 0, 1, -1);

    run_load("poke", 0, 0, 5);

    // in_valid with no start while idle.
    wlog.delete();
    in_valid = 1'b1; in_r = 16'h1234; in_i = 16'h5678;
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    chk("idle_nwrites", wlog.size(), 0);

    // start coincident with reset must lose.
    start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    #2;
    chk("rst_wins_busy", busy, 0);
    chk("rst_wins_ready", in_ready, 0);

`ifdef TWIDDLE_LOADER_CHKSUM_EN
    tick();
    run_load("chk_ones", 0, 2, -1);
    run_load("chk_ff", 0, 3, -1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
